iter_muldiv: RTL and testbench



---
 rtl/iter_muldiv.sv | 173 +++++++++++++++++
 tb/tb_iter_muldiv.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// signed ops handled as magnitudes with the sign re-applied on entry to FIN.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // Two's-complement magnitude of an operand when the op is signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] x,
                                                    input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] x,
                                                       input logic neg);
    return neg ? -x : x;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [1:0]       flags_q;

  logic [1:0]       op_q;
  logic             neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q;

  logic             accept, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0] quo_fin, rem_fin, fin_lo, fin_hi;
  logic [1:0]       fin_flags;

  assign accept = start && (state_q != S_RUN);
  assign b_zero = (b == '0);
  assign a_mag  = magnitude(a, op[0]);
  assign b_mag  = magnitude(b, op[0]);

  // One iteration: right-shift multiply step or restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    hi_d      = mul_sum[WIDTH:1];
    lo_d      = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Signed results and flags from the final iteration, captured on entry to FIN.
  always_comb begin
    prod_fin = apply_sign_2w({hi_d, lo_d}, neg_lo_q);
    quo_fin  = apply_sign_w(lo_d, neg_lo_q);
    rem_fin  = apply_sign_w(hi_d, neg_hi_q);
    if (op_q[1]) begin
      fin_lo    = quo_fin;
      fin_hi    = rem_fin;
      fin_flags = {quo_fin[WIDTH-1], quo_fin == '0};
    end else begin
      fin_lo    = prod_fin[WIDTH-1:0];
      fin_hi    = prod_fin[2*WIDTH-1:WIDTH];
      fin_flags = {prod_fin[2*WIDTH-1], prod_fin == '0};
    end
  end

  // Operand latch and iteration registers (no reset needed: always loaded on accept).
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op;
      neg_lo_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= op[0] & a[WIDTH-1];
      hi_q     <= '0;
      if (op[1]) begin
        opnd_q <= b_mag;
        lo_q   <= a_mag;
      end else begin
        opnd_q <= a_mag;
        lo_q   <= b_mag;
      end
    end else if (state_q == S_RUN) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= 2'b00;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (op[1] && b_zero) begin
          // Divide by zero skips RUN entirely.
          state_q  <= S_FIN;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          res_lo_q <= '1;
          res_hi_q <= a;
          flags_q  <= 2'b10;
          dz_q     <= 1'b1;
        end else begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          cnt_q   <= CNT_W'(WIDTH);
          dz_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          S_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
              state_q  <= S_FIN;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              res_lo_q <= fin_lo;
              res_hi_q <= fin_hi;
              flags_q  <= fin_flags;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_FIN:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Bench for iter_muldiv: arithmetic reference model with latency tracking,
// per-cycle output comparison, directed literal cases and randomized traffic.
module tb_iter_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] result_lo, result_hi;
  logic [1:0]   flags;

  always #5 clk = ~clk;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags), .div_zero(div_zero)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pure arithmetic reference for one operation.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic [1:0] fl, output logic dz);
    logic [2*W-1:0] p;
    logic signed [2*W-1:0] sx, sy, sq, sr;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    dz = 1'b0;
    if (!o[1]) begin
      if (o[0]) p = sx * sy;
      else      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      lo = p[W-1:0];
      hi = p[2*W-1:W];
      fl = {p[2*W-1], p == '0};
    end else if (y == '0) begin
      lo = '1;
      hi = x;
      fl = 2'b10;
      dz = 1'b1;
    end else begin
      if (o[0]) begin
        sq = sx / sy;
        sr = sx % sy;
        lo = sq[W-1:0];
        hi = sr[W-1:0];
      end else begin
        lo = x / y;
        hi = x % y;
      end
      fl = {lo[W-1], lo == '0};
    end
  endfunction

  // Expected-output tracker: an accepted op completes W edges later.
  int cyc = 0;
  int done_at = 0;
  bit inflight = 1'b0;
  logic [W-1:0] e_lo = '0, e_hi = '0, p_lo, p_hi;
  logic [1:0]   e_fl = '0, p_fl;
  logic         e_dz = 1'b0, p_dz, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      inflight = 1'b0;
      e_busy = 1'b0; e_done = 1'b0;
      e_lo = '0; e_hi = '0; e_fl = '0; e_dz = 1'b0;
    end else begin
      e_done = 1'b0;
      if (inflight) begin
        if (cyc == done_at) begin
          inflight = 1'b0;
          e_done = 1'b1;
          e_lo = p_lo; e_hi = p_hi; e_fl = p_fl; e_dz = p_dz;
        end
      end else if (start) begin
        model(op, a, b, p_lo, p_hi, p_fl, p_dz);
        e_dz = 1'b0;
        if (op[1] && b == '0) begin
          e_done = 1'b1;
          e_lo = p_lo; e_hi = p_hi; e_fl = p_fl; e_dz = p_dz;
        end else begin
          inflight = 1'b1;
          done_at = cyc + W;
        end
      end
      e_busy = inflight;
    end
  end

  // Per-cycle comparison of every output against the tracker.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("result_lo", result_lo, e_lo);
      chk("result_hi", result_hi, e_hi);
      chk("flags", flags, e_fl);
      chk("div_zero", div_zero, e_dz);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic await_done(input int max, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL await_done timeout cycles=%0d required done=1", max);
  endtask

  task automatic directed(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] xlo, input logic [W-1:0] xhi,
                          input logic [1:0] xfl, input logic xdz, input int xlat, input int xbusy);
    int lat, nb;
    issue(o, x, y);
    await_done(60, lat, nb);
    chk({name, "_latency"}, lat, xlat);
    chk({name, "_busy_cycles"}, nb, xbusy);
    chk({name, "_lo"}, result_lo, xlo);
    chk({name, "_hi"}, result_hi, xhi);
    chk({name, "_flags"}, flags, xfl);
    chk({name, "_div_zero"}, div_zero, xdz);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] mlo, mhi;
    logic [1:0]   mfl;
    logic         mdz, seen;
    int lat, nb;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    tick;
    chk_en = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lo", result_lo, 0);
    chk("reset_hi", result_hi, 0);
    chk("reset_flags", flags, 0);
    chk("reset_div_zero", div_zero, 0);

    // Pin the reference model against hand-computed values.
    model(2'b11, 32'hFFFF_FFF9, 32'd2, mlo, mhi, mfl, mdz);
    chk("model_sdiv_lo", mlo, 32'hFFFF_FFFD);
    chk("model_sdiv_hi", mhi, 32'hFFFF_FFFF);
    model(2'b01, 32'hFFFF_FFFD, 32'd7, mlo, mhi, mfl, mdz);
    chk("model_smul", {mhi, mlo}, 64'hFFFF_FFFF_FFFF_FFEB);

    directed("umul_max", 2'b00, '1, '1, 32'h0000_0001, 32'hFFFF_FFFE, 2'b10, 1'b0, 33, 32);
    directed("smul_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 2'b10, 1'b0, 33, 32);
    directed("sdiv_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b10, 1'b0, 33, 32);
    directed("sdiv_min", 2'b11, 32'h8000_0000, '1, 32'h8000_0000, 32'h0, 2'b10, 1'b0, 33, 32);
    directed("udiv_zero", 2'b10, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 2'b10, 1'b1, 1, 0);
    directed("sdiv_zero", 2'b11, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 2'b10, 1'b1, 1, 0);
    directed("umul_zero", 2'b00, 32'h0, 32'h5, 32'h0, 32'h0, 2'b01, 1'b0, 33, 32);
    directed("udiv_small", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 2'b00, 1'b0, 33, 32);

    // Ignored start mid-run, then reset abort.
    tick;
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    tick;
    start = 1'b0; op = 2'b01; a = $urandom; b = $urandom;
    repeat (9) tick;
    op = 2'b10; a = 32'd7; b = 32'd9; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_lo", result_lo, 0);
    chk("abort_hi", result_hi, 0);
    chk("abort_flags", flags, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);

    // Back-to-back: start held through RUN into FIN with new operands.
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    tick;
    op = 2'b10; a = 32'd100; b = 32'd7;
    await_done(60, lat, nb);
    chk("b2b_first_latency", lat, 33);
    chk("b2b_first_lo", result_lo, 32'd30);
    chk("b2b_first_hi", result_hi, 32'd0);
    tick;
    start = 1'b0;
    await_done(60, lat, nb);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_busy", nb, 32);
    chk("b2b_second_lo", result_lo, 32'd14);
    chk("b2b_second_hi", result_hi, 32'd2);

    // Randomized traffic: operands and op change every cycle, sporadic start and reset.
    for (int i = 0; i < 3000; i++) begin
      op = 2'($urandom);
      a = pick();
      b = pick();
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick;
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
